// File: rtl/div_unit_pkg.sv
// ============================================================================
// Module   : div_unit_pkg
// Purpose  : Shared encodings for the EX-stage multi-cycle divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package div_unit_pkg;

    localparam int DIV_CNT_W = 6;

    // ALU control codes decoded by EX to drive start/signed_div
    localparam logic [4:0] DIV_CONTROL  = 5'b10110;
    localparam logic [4:0] DIVU_CONTROL = 5'b10111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ON   = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_unit_step.sv
// ============================================================================
// Module   : div_step
// Purpose  : One restoring-division iteration on the {rem, quo} register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] w_upper;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    // Upper half after the left shift, carry bit kept for the borrow test
    assign w_upper  = acc_i[2*WIDTH-1:WIDTH-1];
    assign w_diff   = w_upper - {1'b0, divisor_i};
    assign w_borrow = w_diff[WIDTH];

    always_comb begin
        if (w_borrow) begin
            acc_o = {w_upper[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end else begin
            acc_o = {w_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : 32-bit multi-cycle restoring divider (DIV/DIVU) returning LO/HI.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    div_state_e             state_q, state_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       dvsr_q, dvsr_d;
    logic                   qneg_q, qneg_d;
    logic                   rneg_q, rneg_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [WIDTH-1:0]       hi_q, hi_d;

    logic [2*WIDTH-1:0]     w_step;
    logic [WIDTH-1:0]       w_abs_a;
    logic [WIDTH-1:0]       w_abs_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .divisor_i (dvsr_q),
        .acc_o     (w_step)
    );

    // Magnitudes; 0x80000000 negates to itself, which is correct as unsigned
    assign w_abs_a = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_abs_b = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvsr_d  = dvsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        lo_d    = lo_q;
        hi_d    = hi_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        state_d = DIV_DONE;
                        lo_d    = '1;
                        hi_d    = a;
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, w_abs_a};
                        dvsr_d  = w_abs_b;
                        qneg_d  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d  = signed_div & a[WIDTH-1];
                    end
                end
            end
            DIV_ON: begin
                acc_d = w_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_DONE;
                    lo_d    = qneg_q ? (~w_step[WIDTH-1:0] + 1'b1) : w_step[WIDTH-1:0];
                    hi_d    = rneg_q ? (~w_step[2*WIDTH-1:WIDTH] + 1'b1)
                                     : w_step[2*WIDTH-1:WIDTH];
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        // Flush wins over any transition and leaves the last result visible
        if (cancel) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
            lo_d    = lo_q;
            hi_d    = hi_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvsr_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvsr_q  <= dvsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign busy   = (state_q == DIV_ON);
    assign ready  = (state_q == DIV_DONE);
    assign lo_out = lo_q;
    assign hi_out = hi_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Scoreboard-driven self-checking bench for div_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        ready;
    logic [31:0] lo_out;
    logic [31:0] hi_out;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .cancel     (cancel),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .ready      (ready),
        .lo_out     (lo_out),
        .hi_out     (hi_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    input logic s, output logic [31:0] q,
                                    output logic [31:0] r);
        logic [31:0] ux, uy;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (!s) begin
            q = x / y;
            r = x % y;
        end else begin
            ux = x[31] ? (32'd0 - x) : x;
            uy = y[31] ? (32'd0 - y) : y;
            q  = ux / uy;
            r  = ux % uy;
            if (x[31] ^ y[31]) q = 32'd0 - q;
            if (x[31]) r = 32'd0 - r;
        end
    endfunction

    // Drive one start pulse (edge E0) and record what the DUT must return
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         input logic [31:0] elo, input logic [31:0] ehi);
        exp_t e;
        e.lo  = elo;
        e.hi  = ehi;
        e.lat = (ib == 32'd0) ? 1 : 33;
        sb.push_back(e);
        @(negedge clk);
        a = ia; b = ib; signed_div = is; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_ready(output int lat, output int busyc, output bit tmo);
        lat = 0; busyc = 0; tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busyc++;
            if (ready) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, ready} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {busy, ready});
        else n_pass++;
        n_total++;
        if ({lo_out, hi_out} !== 64'd0) $display("FAIL reset_result: got %h want 0", {lo_out, hi_out});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, ready} !== 2'b00) $display("FAIL idle_flags: got %b want 00", {busy, ready});
        else n_pass++;
    endtask

    task automatic test_unsigned;
        int lat, bc; bit tmo; exp_t e;
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        wait_ready(lat, bc, tmo);
        e = sb.pop_front();
        n_total++;
        if (tmo || lat != e.lat) $display("FAIL udiv_latency: got %0d (timeout=%0d) want %0d", lat, tmo, e.lat);
        else n_pass++;
        n_total++;
        if (bc != 32) $display("FAIL udiv_busy_cycles: got %0d want 32", bc);
        else n_pass++;
        n_total++;
        if ({lo_out, hi_out} !== {e.lo, e.hi}) $display("FAIL udiv_result: got %h/%h want %h/%h", lo_out, hi_out, e.lo, e.hi);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (ready !== 1'b0) $display("FAIL ready_pulse_width: got %b want 0", ready);
        else n_pass++;
    endtask

    task automatic test_signed;
        int lat, bc; bit tmo; exp_t e;
        logic [31:0] va[4] = '{32'hFFFF_FFF9, 32'd7,         32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb[4] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic        vs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] vl[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0};
        logic [31:0] vh[4] = '{32'hFFFF_FFFF, 32'd1,         32'd0,         32'h8000_0000};
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], vs[i], vl[i], vh[i]);
            wait_ready(lat, bc, tmo);
            e = sb.pop_front();
            n_total++;
            if (tmo || lat != e.lat) $display("FAIL sdiv_latency[%0d]: got %0d want %0d", i, lat, e.lat);
            else n_pass++;
            n_total++;
            if ({lo_out, hi_out} !== {e.lo, e.hi}) $display("FAIL sdiv_result[%0d]: got %h/%h want %h/%h", i, lo_out, hi_out, e.lo, e.hi);
            else n_pass++;
        end
    endtask

    task automatic test_div_zero;
        int lat, bc; bit tmo; exp_t e;
        for (int m = 0; m < 2; m++) begin
            issue(32'd1234, 32'd0, m[0], 32'hFFFF_FFFF, 32'd1234);
            wait_ready(lat, bc, tmo);
            e = sb.pop_front();
            n_total++;
            if (tmo || lat != e.lat) $display("FAIL dz_latency[%0d]: got %0d want %0d", m, lat, e.lat);
            else n_pass++;
            n_total++;
            if (bc != 0) $display("FAIL dz_busy[%0d]: got %0d busy cycles want 0", m, bc);
            else n_pass++;
            n_total++;
            if ({lo_out, hi_out} !== {e.lo, e.hi}) $display("FAIL dz_result[%0d]: got %h/%h want %h/%h", m, lo_out, hi_out, e.lo, e.hi);
            else n_pass++;
        end
    endtask

    task automatic test_cancel;
        int lat, bc, seen; bit tmo; exp_t e;
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        wait_ready(lat, bc, tmo);
        e = sb.pop_front();
        n_total++;
        if (tmo || {lo_out, hi_out} !== {e.lo, e.hi}) $display("FAIL cancel_setup: got %h/%h want %h/%h", lo_out, hi_out, e.lo, e.hi);
        else n_pass++;
        @(negedge clk);
        a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        n_total++;
        if (busy !== 1'b0) $display("FAIL cancel_busy: got %b want 0", busy);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready || busy) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL cancel_no_ready: got %0d active cycles want 0", seen);
        else n_pass++;
        n_total++;
        if ({lo_out, hi_out} !== {32'd14, 32'd2}) $display("FAIL cancel_hold: got %h/%h want 0000000e/00000002", lo_out, hi_out);
        else n_pass++;
        issue(32'd9, 32'd4, 1'b0, 32'd2, 32'd1);
        wait_ready(lat, bc, tmo);
        e = sb.pop_front();
        n_total++;
        if (tmo || lat != e.lat || {lo_out, hi_out} !== {e.lo, e.hi})
            $display("FAIL cancel_recover: got %h/%h lat %0d want %h/%h lat %0d", lo_out, hi_out, lat, e.lo, e.hi, e.lat);
        else n_pass++;
    endtask

    task automatic test_start_ignored;
        int lat, bc, seen; bit tmo; exp_t e;
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        repeat (10) @(negedge clk);
        a = 32'd5; b = 32'd1; signed_div = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready(lat, bc, tmo);
        e = sb.pop_front();
        n_total++;
        if (tmo || lat + 11 != e.lat) $display("FAIL ignore_latency: got %0d want %0d", lat + 11, e.lat);
        else n_pass++;
        n_total++;
        if ({lo_out, hi_out} !== {e.lo, e.hi}) $display("FAIL ignore_result: got %h/%h want %h/%h", lo_out, hi_out, e.lo, e.hi);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready || busy) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL ignore_no_extra_op: got %0d active cycles want 0", seen);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        a = 32'd1000; b = 32'd3; signed_div = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, ready, lo_out, hi_out} !== 66'd0)
            $display("FAIL rstmid_async: got busy=%b ready=%b %h/%h want all 0", busy, ready, lo_out, hi_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready || busy) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL rstmid_no_ready: got %0d active cycles want 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat, bc; bit tmo; exp_t e;
        logic [31:0] ra, rb, q, r;
        logic        rs;
        issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);
        wait_ready(lat, bc, tmo);
        e = sb.pop_front();
        n_total++;
        if (tmo || {lo_out, hi_out} !== {e.lo, e.hi}) $display("FAIL b2b_first: got %h/%h want %h/%h", lo_out, hi_out, e.lo, e.hi);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            rs = 1'($urandom_range(0, 1));
            ref_div(ra, rb, rs, q, r);
            issue(ra, rb, rs, q, r);
            wait_ready(lat, bc, tmo);
            e = sb.pop_front();
            n_total++;
            if (tmo || lat != e.lat || {lo_out, hi_out} !== {e.lo, e.hi})
                $display("FAIL b2b[%0d] %h/%h s=%0d: got %h/%h lat %0d want %h/%h lat %0d",
                         i, ra, rb, rs, lo_out, hi_out, lat, e.lo, e.hi, e.lat);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_cancel();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the EX stage, running alongside the ALU for DIV/DIVU. It takes the two register operands, iterates one quotient bit per cycle with a restoring algorithm, and returns quotient/remainder as LO/HI to the HI/LO write path. The pipeline stalls on `busy` and captures the result on the `ready` pulse.

## Interface
Parameters:
- `WIDTH`, default 32: operand, quotient and remainder width. Only 32 is supported.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a division; sampled only in IDLE.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `cancel`  in  1  synchronous abort (pipeline flush or exception).
- `a`  in  32  dividend; sampled with `start`.
- `b`  in  32  divisor; sampled with `start`.
- `busy`  out  1  high while iterating.
- `ready`  out  1  one-cycle pulse: `hi_out`/`lo_out` hold a fresh result.
- `lo_out`  out  32  quotient.
- `hi_out`  out  32  remainder.

## Operation
- State machine IDLE, DIV, DONE. There is a 6-bit iteration counter.
- IDLE -> DIV: on `start=1` and `cancel=0` with `b != 0`.
  - Latch |a| and |b|. In unsigned mode these are the raw values.
  - Latch quotient sign `a[31]^b[31]` and remainder sign `a[31]`. In unsigned mode both signs are forced to 0.
  - Clear the partial remainder (64-bit working register) and the counter.
- IDLE -> DONE: on `start=1`, `cancel=0` and `b == 0`. This is divide-by-zero.
  - Result is `lo_out=32'hFFFFFFFF` and `hi_out=a` (raw), in both modes.
  - No iteration is performed.
- DIV, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the upper half. If there is no borrow, keep the difference and set quotient bit 0 to 1.
  - Increment the counter. After the 32nd step, go to DONE.
- Entering DONE:
  - Apply sign fix-ups: negate the quotient if its sign is 1, negate the remainder if its sign is 1.
  - Register the results into `lo_out`/`hi_out`.
- DONE -> IDLE: unconditionally, after one cycle.
- Arithmetic rules:
  - All iteration is unsigned 33-bit (carry kept for the borrow test).
  - |0x80000000| = 0x80000000 as unsigned.
  - 0x80000000 / -1 (signed) yields `lo_out=0x80000000`, `hi_out=0`. It does not trap.
- `cancel`:
  - Takes priority over everything except `rst`. Any state goes to IDLE on the next edge.
  - No `ready` pulse is produced.
  - `lo_out`/`hi_out` keep their previous values.
  - `start` together with `cancel` is ignored.
- `start` in DIV or DONE is ignored. The caller holds the instruction in EX until `ready`.
- Reset values:
  - state IDLE, counter 0.
  - `busy=0`, `ready=0`, `lo_out=0`, `hi_out=0`.
  - All internal working registers 0.
- Reset mid-division: abandon immediately; no `ready`.

## Timing
- `busy = (state==DIV)` and `ready = (state==DONE)`. Both are decoded from registered state, so both are glitch-free.
- Normal division, with the start edge called E0:
  - `busy` is high from after E0 through E32.
  - `ready` is high in the cycle after E32.
  - So `ready` appears 33 cycles after `start`, and IDLE is reached again after E33.
- Divide-by-zero: `ready` is high in the cycle after E0. `busy` never rises.
- Results are stable from the `ready` cycle until the next completed division.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after `ready`.
- No combinational path from inputs to outputs.

## Structure
- Shared header `defines.h` (already included by the EX-stage blocks) gains:
  - state encodings `DIV_IDLE`, `DIV_ON`, `DIV_DONE` (2 bits);
  - `DIV_CONTROL` and `DIVU_CONTROL` on the 5-bit ALU control code space. The EX-stage decode drives `start`/`signed_div` from these.
- One natural sub-module, `div_step`: combinational single iteration.
  - Inputs: 64-bit {rem, quo}, 32-bit divisor.
  - Output: next {rem, quo}.
  - It is unit-testable in isolation.
- Sign fix-up and FSM live in `div_unit`.

## Test plan
- Unsigned 100/7: `start`, `signed_div=0`, a=100, b=7 -> `ready` exactly 33 cycles after start, `lo_out=14`, `hi_out=2`, `busy` high 32 cycles.
- Signed -7/2: a=32'hFFFFFFF9, b=2, `signed_div=1` -> `lo_out=32'hFFFFFFFD`, `hi_out=32'hFFFFFFFF`. Then 7/-2 -> `lo_out=32'hFFFFFFFD`, `hi_out=1`.
- Overflow corner: a=32'h80000000, b=32'hFFFFFFFF, signed -> `lo_out=32'h80000000`, `hi_out=0`. The same operands unsigned -> `lo_out=0`, `hi_out=32'h80000000`.
- Divide-by-zero: a=1234, b=0 (both modes) -> `ready` one cycle after start, `lo_out=32'hFFFFFFFF`, `hi_out=1234`, `busy` never high.
- Cancel mid-op: previous result 14/2 in `lo_out`/`hi_out`; start 1000/3; assert `cancel` at cycle 10 -> IDLE next edge, no `ready`, outputs still 14/2. The next start 9/4 then completes correctly (`lo_out=2`, `hi_out=1`).
- Reset mid-op: assert `rst` asynchronously at cycle 20 -> `busy`, `ready`, `lo_out`, `hi_out` go to 0 immediately. A `start` pulse during DIV is ignored and leaves the running result unaffected.
